// File: rtl/perclos_calc.sv
// PERCLOS (P80) fatigue metric: calibrates an open-eye reference, classifies each frame,
// keeps a sliding window of closed flags and divides to a percentage with hysteretic alarm.
module perclos_calc #(
  parameter int unsigned WIN        = 60,
  parameter int unsigned CAL_FRAMES = 32,
  parameter int unsigned ALARM_PCT  = 40,
  parameter int unsigned HYST_PCT   = 10,
  parameter int unsigned LONG_CLOSE = 45
) (
  input  logic        module_clk,
  input  logic        module_rst_n,
  input  logic [10:0] lcd_pixel_xpos,
  input  logic [10:0] lcd_pixel_ypos,
  input  logic [10:0] eye1_high,
  input  logic [10:0] eye2_high,
  input  logic        eye_valid,
  output logic [10:0] eye_open_ref,
  output logic        cal_done,
  output logic        eye_closed,
  output logic [7:0]  closed_cnt,
  output logic [6:0]  perclos_pct,
  output logic        perclos_valid,
  output logic        fatigue_alarm,
  output logic        microsleep
);

  localparam int unsigned HW  = 11;
  localparam int unsigned CW  = 8;
  localparam int unsigned PW  = 7;
  localparam int unsigned MW  = 14;
  localparam int unsigned DW  = 15;
  localparam int unsigned QCW = 4;

  typedef enum logic {S_CAL = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_in_cal;
  logic            w_in_run;

  logic [HW-1:0]   r_ref;
  logic [CW-1:0]   r_cal_cnt;
  logic            r_cal_done;
  logic            r_eye_closed;
  logic            r_cls_pend;
  logic            r_win_pend;
  logic [WIN-1:0]  r_win;
  logic [CW-1:0]   r_fill;
  logic [CW-1:0]   r_closed_cnt;
  logic [CW-1:0]   r_consec;
  logic            r_microsleep;

  logic            r_div_busy;
  logic [QCW-1:0]  r_div_cnt;
  logic [DW-1:0]   r_div_dvd;
  logic [CW-1:0]   r_div_rem;
  logic [PW-2:0]   r_div_q;
  logic [PW-1:0]   r_pct;
  logic            r_pvalid;
  logic            r_alarm;

  logic            w_strobe;
  logic            w_frame;
  logic [HW-1:0]   w_h;
  logic [HW-1:0]   w_ref_nxt;
  logic [MW-1:0]   w_h5;
  logic            w_closed_c;
  logic            w_cal_last;
  logic [CW-1:0]   w_consec_nxt;
  logic [CW:0]     w_rem_sh;
  logic            w_ge;
  logic [CW-1:0]   w_rem_nxt;
  logic [PW-1:0]   w_q_nxt;

  assign w_strobe   = (lcd_pixel_xpos == 11'd1) && (lcd_pixel_ypos == 11'd1);
  assign w_frame    = w_strobe && eye_valid;
  assign w_h        = (eye1_high >= eye2_high) ? eye1_high : eye2_high;
  assign w_ref_nxt  = (w_h > r_ref) ? w_h : r_ref;
  assign w_h5       = MW'(w_h) * MW'(5);
  assign w_closed_c = (r_ref != '0) && (w_h5 <= MW'(r_ref));
  assign w_cal_last = (r_cal_cnt == CW'(CAL_FRAMES - 1));

  // FSM: state register
  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) r_state <= S_CAL;
    else               r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_CAL && w_frame && w_cal_last) w_state_nxt = S_RUN;
  end

  // FSM: decoded state
  always_comb begin
    w_in_cal = 1'b0;
    w_in_run = 1'b0;
    if (r_state == S_CAL) w_in_cal = 1'b1;
    else                  w_in_run = 1'b1;
  end

  // Reference tracking, calibration count and classification at the frame strobe
  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      r_ref        <= '0;
      r_cal_cnt    <= '0;
      r_cal_done   <= 1'b0;
      r_eye_closed <= 1'b0;
      r_cls_pend   <= 1'b0;
    end else begin
      r_cls_pend <= w_frame && w_in_run;
      if (w_frame) begin
        r_ref <= w_ref_nxt;
        if (w_in_cal) begin
          r_cal_cnt <= r_cal_cnt + CW'(1);
          if (w_cal_last) r_cal_done <= 1'b1;
        end else begin
          r_eye_closed <= w_closed_c;
        end
      end
    end
  end

  assign w_consec_nxt = !r_eye_closed ? '0 :
                        (r_consec == '1) ? r_consec : r_consec + CW'(1);

  // Sliding window, closed count and consecutive-closure tracking
  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      r_win        <= '0;
      r_fill       <= '0;
      r_closed_cnt <= '0;
      r_consec     <= '0;
      r_microsleep <= 1'b0;
      r_win_pend   <= 1'b0;
    end else begin
      r_win_pend <= r_cls_pend;
      if (r_cls_pend) begin
        r_win        <= {r_win[WIN-2:0], r_eye_closed};
        r_consec     <= w_consec_nxt;
        r_microsleep <= (w_consec_nxt >= CW'(LONG_CLOSE));
        if (r_fill < CW'(WIN)) begin
          r_fill       <= r_fill + CW'(1);
          r_closed_cnt <= r_closed_cnt + CW'(r_eye_closed);
        end else begin
          r_closed_cnt <= r_closed_cnt + CW'(r_eye_closed) - CW'(r_win[WIN-1]);
        end
      end
    end
  end

  // Restoring division step: remainder stays below WIN so fits in CW bits
  assign w_rem_sh  = {r_div_rem, r_div_dvd[DW-1]};
  assign w_ge      = (w_rem_sh >= (CW+1)'(WIN));
  assign w_rem_nxt = w_ge ? CW'(w_rem_sh - (CW+1)'(WIN)) : w_rem_sh[CW-1:0];
  assign w_q_nxt   = {r_div_q, w_ge};

  // Sequential divider, percentage output and hysteretic alarm
  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      r_div_busy <= 1'b0;
      r_div_cnt  <= '0;
      r_div_dvd  <= '0;
      r_div_rem  <= '0;
      r_div_q    <= '0;
      r_pct      <= '0;
      r_pvalid   <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_pvalid <= 1'b0;
      if (r_div_busy) begin
        r_div_dvd <= {r_div_dvd[DW-2:0], 1'b0};
        r_div_rem <= w_rem_nxt;
        r_div_q   <= w_q_nxt[PW-2:0];
        r_div_cnt <= r_div_cnt + QCW'(1);
        if (r_div_cnt == QCW'(DW - 1)) begin
          r_div_busy <= 1'b0;
          r_pct      <= w_q_nxt;
          r_pvalid   <= 1'b1;
          if (w_q_nxt >= PW'(ALARM_PCT))                r_alarm <= 1'b1;
          else if (w_q_nxt < PW'(ALARM_PCT - HYST_PCT)) r_alarm <= 1'b0;
        end
      end else if (r_win_pend && (r_fill == CW'(WIN))) begin
        r_div_busy <= 1'b1;
        r_div_cnt  <= '0;
        r_div_dvd  <= DW'(r_closed_cnt) * DW'(100);
        r_div_rem  <= '0;
        r_div_q    <= '0;
      end
    end
  end

  assign eye_open_ref  = r_ref;
  assign cal_done      = r_cal_done;
  assign eye_closed    = r_eye_closed;
  assign closed_cnt    = r_closed_cnt;
  assign perclos_pct   = r_pct;
  assign perclos_valid = r_pvalid;
  assign fatigue_alarm = r_alarm;
  assign microsleep    = r_microsleep;

endmodule

// File: tb/tb_perclos_calc.sv
// Self-checking bench for perclos_calc: directed table, multi-frame scenarios and
// randomized frames against a queue-based reference model.
module tb_perclos_calc;

  localparam int unsigned WIN   = 60;
  localparam int unsigned CAL   = 32;
  localparam int unsigned ALARM = 40;
  localparam int unsigned HYST  = 10;
  localparam int unsigned LONGC = 45;

  logic        clk;
  logic        rst_n;
  logic [10:0] xpos, ypos, e1, e2;
  logic        ev;
  logic [10:0] eye_open_ref;
  logic        cal_done, eye_closed, perclos_valid, fatigue_alarm, microsleep;
  logic [7:0]  closed_cnt;
  logic [6:0]  perclos_pct;

  perclos_calc #(.WIN(WIN), .CAL_FRAMES(CAL), .ALARM_PCT(ALARM), .HYST_PCT(HYST),
                 .LONG_CLOSE(LONGC)) dut (
    .module_clk(clk), .module_rst_n(rst_n),
    .lcd_pixel_xpos(xpos), .lcd_pixel_ypos(ypos),
    .eye1_high(e1), .eye2_high(e2), .eye_valid(ev),
    .eye_open_ref(eye_open_ref), .cal_done(cal_done), .eye_closed(eye_closed),
    .closed_cnt(closed_cnt), .perclos_pct(perclos_pct), .perclos_valid(perclos_valid),
    .fatigue_alarm(fatigue_alarm), .microsleep(microsleep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: frame-level behaviour with plain arithmetic and a queue window
  int m_ref, m_cal_cnt, m_pct, m_consec, m_cnt;
  bit m_cal_done, m_closed, m_alarm, m_ms;
  bit m_q[$];

  function automatic void m_reset();
    m_ref = 0; m_cal_cnt = 0; m_pct = 0; m_consec = 0; m_cnt = 0;
    m_cal_done = 0; m_closed = 0; m_alarm = 0; m_ms = 0;
    m_q.delete();
  endfunction

  function automatic bit model_frame(input int h1, input int h2, input bit v);
    int h;
    h = (h1 > h2) ? h1 : h2;
    if (!v) return 1'b0;
    if (!m_cal_done) begin
      if (h > m_ref) m_ref = h;
      m_cal_cnt++;
      if (m_cal_cnt == CAL) m_cal_done = 1;
      return 1'b0;
    end
    m_closed = (m_ref != 0) && (h * 5 <= m_ref);
    if (h > m_ref) m_ref = h;
    m_q.push_back(m_closed);
    if (m_q.size() > WIN) void'(m_q.pop_front());
    m_cnt = 0;
    foreach (m_q[i]) m_cnt += int'(m_q[i]);
    m_consec = m_closed ? ((m_consec < 255) ? m_consec + 1 : 255) : 0;
    m_ms = (m_consec >= LONGC);
    if (m_q.size() < WIN) return 1'b0;
    m_pct = m_cnt * 100 / WIN;
    if (m_pct >= ALARM) m_alarm = 1;
    else if (m_pct < ALARM - HYST) m_alarm = 0;
    return 1'b1;
  endfunction

  task automatic idle_inputs();
    xpos = 11'd7; ypos = 11'd3;
    e1 = 11'($urandom); e2 = 11'($urandom); ev = 1'($urandom);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ref"}, int'(eye_open_ref), 0);
    check({tag, "_cal_done"}, int'(cal_done), 0);
    check({tag, "_closed"}, int'(eye_closed), 0);
    check({tag, "_cnt"}, int'(closed_cnt), 0);
    check({tag, "_pct"}, int'(perclos_pct), 0);
    check({tag, "_pvalid"}, int'(perclos_valid), 0);
    check({tag, "_alarm"}, int'(fatigue_alarm), 0);
    check({tag, "_ms"}, int'(microsleep), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  // One frame: strobe cycle T, then 24 cycles observing timing of each output
  task automatic frame(input int h1, input int h2, input bit v);
    bit exp_p;
    int pc, pn;
    @(negedge clk);
    xpos = 11'd1; ypos = 11'd1; e1 = 11'(h1); e2 = 11'(h2); ev = v;
    exp_p = model_frame(h1, h2, v);
    pc = 0; pn = 0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        idle_inputs();
        check("eye_closed", int'(eye_closed), int'(m_closed));
        check("cal_done", int'(cal_done), int'(m_cal_done));
        check("eye_open_ref", int'(eye_open_ref), m_ref);
      end
      if (c == 2) begin
        check("closed_cnt", int'(closed_cnt), m_cnt);
        check("microsleep", int'(microsleep), int'(m_ms));
      end
      if (perclos_valid) begin
        pn++;
        if (pc == 0) pc = c;
      end
    end
    check("pvalid_cycle", pc, exp_p ? 18 : 0);
    check("pvalid_count", pn, int'(exp_p));
    check("perclos_pct", int'(perclos_pct), m_pct);
    check("fatigue_alarm", int'(fatigue_alarm), int'(m_alarm));
  endtask

  typedef struct {
    int h1;
    int h2;
    bit v;
    bit exp_closed;
    int exp_ref;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int h, h2;
    bit v;
    tbl[0] = '{10, 3, 1'b1, 1'b1, 50};
    tbl[1] = '{2, 11, 1'b1, 1'b0, 50};
    tbl[2] = '{9, 9, 1'b0, 1'b0, 50};
    tbl[3] = '{10, 7, 1'b1, 1'b1, 50};
    tbl[4] = '{8, 8, 1'b0, 1'b1, 50};
    tbl[5] = '{0, 0, 1'b1, 1'b1, 50};
    tbl[6] = '{1, 12, 1'b1, 1'b0, 50};

    rst_n = 1'b0;
    xpos = 11'd0; ypos = 11'd0; e1 = '0; e2 = '0; ev = 1'b0;
    m_reset();
    #12;
    check_zero("reset");
    do_reset("reset2");

    // Calibration with heights 20..51 split across the two eyes
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) frame(20 + i, 0, 1'b1);
      else            frame(3, 20 + i, 1'b1);
      if (i == 30) check("cal_not_yet", int'(cal_done), 0);
    end
    check("cal1_done", int'(cal_done), 1);
    check("cal1_ref", int'(eye_open_ref), 51);
    check("cal1_closed", int'(eye_closed), 0);

    // Recalibrate to ref=50, then classification table
    do_reset("reset3");
    for (int i = 0; i < 32; i++) frame(19 + i, 0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      frame(tbl[i].h1, tbl[i].h2, tbl[i].v);
      check("tbl_closed", int'(eye_closed), int'(tbl[i].exp_closed));
      check("tbl_ref", int'(eye_open_ref), tbl[i].exp_ref);
    end

    // Window fill: 24 closed then 36 open
    do_reset("reset4");
    for (int i = 0; i < 32; i++) frame(19 + i, 0, 1'b1);
    for (int i = 0; i < 24; i++) frame(5, 2, 1'b1);
    for (int i = 0; i < 36; i++) frame(40, 1, 1'b1);
    check("fill_cnt", int'(closed_cnt), 24);
    check("fill_pct", int'(perclos_pct), 40);
    check("fill_alarm", int'(fatigue_alarm), 1);

    // Alarm hysteresis
    for (int i = 0; i < 6; i++) frame(40, 1, 1'b1);
    check("hyst_pct30", int'(perclos_pct), 30);
    check("hyst_hold", int'(fatigue_alarm), 1);
    frame(40, 1, 1'b1);
    check("hyst_pct28", int'(perclos_pct), 28);
    check("hyst_clear", int'(fatigue_alarm), 0);

    // Microsleep: 45 closed valid frames with 3 invalid frames interleaved
    for (int i = 1; i <= 45; i++) begin
      frame(4, 6, 1'b1);
      if (i == 10 || i == 20 || i == 30) frame(4, 6, 1'b0);
      if (i == 44) check("ms_before", int'(microsleep), 0);
    end
    check("ms_set", int'(microsleep), 1);
    frame(45, 0, 1'b1);
    check("ms_clear", int'(microsleep), 0);

    // Randomized frames around the classification threshold
    for (int i = 0; i < 150; i++) begin
      h  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(40, 60)) : int'($urandom_range(0, 16));
      h2 = int'($urandom_range(0, h));
      v  = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 1) == 1) frame(h, h2, v);
      else                           frame(h2, h, v);
    end

    // Reset while the divider is running
    @(negedge clk);
    xpos = 11'd1; ypos = 11'd1; e1 = 11'd5; e2 = 11'd0; ev = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (7) @(negedge clk);
    do_reset("mid_div");
    for (int i = 0; i < 31; i++) frame(30, 10, 1'b1);
    check("recal_pending", int'(cal_done), 0);
    frame(30, 10, 1'b1);
    check("recal_done", int'(cal_done), 1);
    frame(3, 2, 1'b1);
    check("recal_classify", int'(eye_closed), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
